// File: rtl/rx_frame_parser.sv
// GMII-style receive frame parser: strips preamble/SFD, forwards frame bytes one cycle late,
// checks CRC-32, length and PHY errors, and keeps saturating good/bad frame counters.
module rx_frame_parser #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGHT = 64,
  parameter int pMAX_PACKET_LENGHT = 1536
) (
  input  logic                   iclk,
  input  logic                   i_rst_n,
  input  logic                   i_rx_dv,
  input  logic                   i_rx_er,
  input  logic [pDATA_WIDTH-1:0] i_rxd,
  output logic [pDATA_WIDTH-1:0] o_rx_d,
  output logic                   o_dv,
  output logic                   o_error,
  output logic [2:0]             o_FSM_state,
  output logic [15:0]            o_frames_ok,
  output logic [15:0]            o_frames_bad
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    PREAMBLE = 3'b001,
    DATA     = 3'b010,
    CHECK    = 3'b011,
    DROP     = 3'b100
  } state_t;

  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE    = pDATA_WIDTH'(8'h55);
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE    = pDATA_WIDTH'(8'hD5);
  localparam logic [31:0]            CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]            CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0]            CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0]            MIN_CNT     = 11'(pMIN_PACKET_LENGHT);
  localparam logic [10:0]            MAX_CNT     = 11'(pMAX_PACKET_LENGHT);

  state_t                   state_q, state_d;
  logic [31:0]              crc_q, crc_d;
  logic [10:0]              cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     chk_q, chk_d;
  logic [pDATA_WIDTH-1:0]   rx_d_q, rx_d_d;
  logic                     dv_q, dv_d;
  logic                     error_q, error_d;
  logic [15:0]              ok_q, ok_d;
  logic [15:0]              bad_q, bad_d;
  logic                     frame_bad;

  function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [pDATA_WIDTH-1:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < pDATA_WIDTH; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // CRC over the whole frame including FCS leaves the fixed residue when intact.
  assign frame_bad = (crc_q != CRC_RESIDUE) || (cnt_q < MIN_CNT) || err_q;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    chk_d   = 1'b0;
    rx_d_d  = rx_d_q;
    dv_d    = 1'b0;
    error_d = 1'b0;
    ok_d    = ok_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (i_rx_dv) begin
          if (i_rxd == PRE_BYTE) begin
            state_d = PREAMBLE;
            crc_d   = CRC_INIT;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = DROP;
          end
        end
      end
      PREAMBLE: begin
        if (!i_rx_dv)                state_d = IDLE;
        else if (i_rxd == SFD_BYTE)  state_d = DATA;
        else if (i_rxd != PRE_BYTE)  state_d = DROP;
      end
      DATA: begin
        if (!i_rx_dv) begin
          state_d = CHECK;
          error_d = frame_bad;
        end else if (cnt_q == MAX_CNT) begin
          state_d = DROP;
          error_d = 1'b1;
          bad_d   = sat_inc(bad_q);
        end else begin
          rx_d_d = i_rxd;
          dv_d   = 1'b1;
          cnt_d  = cnt_q + 11'd1;
          crc_d  = crc_next(crc_q, i_rxd);
          if (i_rx_er) err_d = 1'b1;
        end
      end
      CHECK: begin
        if (!chk_q) begin
          chk_d   = 1'b1;
          error_d = frame_bad;
        end else begin
          state_d = IDLE;
          if (frame_bad) bad_d = sat_inc(bad_q);
          else           ok_d  = sat_inc(ok_q);
        end
      end
      DROP: begin
        if (!i_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      crc_q   <= CRC_INIT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      chk_q   <= 1'b0;
      rx_d_q  <= '0;
      dv_q    <= 1'b0;
      error_q <= 1'b0;
      ok_q    <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
      rx_d_q  <= rx_d_d;
      dv_q    <= dv_d;
      error_q <= error_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  assign o_rx_d       = rx_d_q;
  assign o_dv         = dv_q;
  assign o_error      = error_q;
  assign o_FSM_state  = state_q;
  assign o_frames_ok  = ok_q;
  assign o_frames_bad = bad_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// Bench for rx_frame_parser: frames built with a real Ethernet FCS, expected forwarding,
// error timing and counters derived from frame-level rules.
module tb_rx_frame_parser;

  localparam int MIN = 64;
  localparam int MAX = 1536;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];

  logic        iclk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_rx_dv = 1'b0;
  logic        i_rx_er = 1'b0;
  logic [7:0]  i_rxd = 8'h00;
  logic [7:0]  o_rx_d;
  logic        o_dv;
  logic        o_error;
  logic [2:0]  o_FSM_state;
  logic [15:0] o_frames_ok;
  logic [15:0] o_frames_bad;

  rx_frame_parser #(
    .pDATA_WIDTH(8),
    .pMIN_PACKET_LENGHT(MIN),
    .pMAX_PACKET_LENGHT(MAX)
  ) dut (
    .iclk(iclk),
    .i_rst_n(i_rst_n),
    .i_rx_dv(i_rx_dv),
    .i_rx_er(i_rx_er),
    .i_rxd(i_rxd),
    .o_rx_d(o_rx_d),
    .o_dv(o_dv),
    .o_error(o_error),
    .o_FSM_state(o_FSM_state),
    .o_frames_ok(o_frames_ok),
    .o_frames_bad(o_frames_bad)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int exp_ok = 0;
  int exp_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Output monitor, sampled on the falling edge.
  byte_t cap[$];
  int    err_cyc[$];
  int    err_cnt;
  int    first_dv;
  int    last_dv;

  task automatic clear_mon();
    cap.delete();
    err_cyc.delete();
    err_cnt  = 0;
    first_dv = -1;
    last_dv  = -1;
  endtask

  always @(negedge iclk) begin
    if (o_dv) begin
      cap.push_back(o_rx_d);
      if (first_dv < 0) first_dv = cyc;
      last_dv = cyc;
    end
    if (o_error) begin
      err_cnt++;
      err_cyc.push_back(cyc);
    end
  end

  function automatic logic [31:0] fcs_of(input bq_t d);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input bq_t b);
    bq_t p;
    int  n;
    n = b.size();
    if (n < 4) return 1'b0;
    for (int i = 0; i < n - 4; i++) p.push_back(b[i]);
    return {b[n-1], b[n-2], b[n-3], b[n-4]} == fcs_of(p);
  endfunction

  // Payload avoids 8'h55 so a frame cut by reset cannot look like a fresh preamble.
  function automatic bq_t make_body(input int plen);
    bq_t         b;
    logic [31:0] f;
    byte_t       x;
    for (int i = 0; i < plen; i++) begin
      x = byte_t'($urandom_range(0, 255));
      if (x == 8'h55) x = 8'h54;
      b.push_back(x);
    end
    f = fcs_of(b);
    b.push_back(f[7:0]);
    b.push_back(f[15:8]);
    b.push_back(f[23:16]);
    b.push_back(f[31:24]);
    return b;
  endfunction

  task automatic send(input bq_t pre, input bq_t body, input int er_pos, input bit exp_drop,
                      output int start_cyc);
    start_cyc = -1;
    foreach (pre[i]) begin
      @(posedge iclk); #1;
      i_rx_dv = 1'b1; i_rxd = pre[i]; i_rx_er = 1'b0;
    end
    foreach (body[i]) begin
      @(posedge iclk); #1;
      if (i == 0) start_cyc = cyc;
      i_rx_dv = 1'b1; i_rxd = body[i]; i_rx_er = (i == er_pos);
    end
    if (exp_drop) begin
      @(negedge iclk);
      chk("drop_state", int'(o_FSM_state), 4);
    end
    @(posedge iclk); #1;
    i_rx_dv = 1'b0; i_rx_er = 1'b0; i_rxd = 8'h00;
    repeat (8) @(posedge iclk);
    @(negedge iclk);
  endtask

  task automatic run(input string name, input bq_t pre, input bq_t body, input int er_pos);
    bit valid, good;
    int len, exp_fwd, exp_err, start, mism, n;
    valid = (pre.size() > 1) && (pre[pre.size()-1] == 8'hD5);
    for (int i = 0; i < pre.size() - 1; i++) if (pre[i] != 8'h55) valid = 1'b0;
    len     = body.size();
    good    = valid && len >= MIN && len <= MAX && er_pos < 0 && fcs_ok(body);
    exp_fwd = !valid ? 0 : (len > MAX ? MAX : len);
    exp_err = !valid ? 0 : (len > MAX ? 1 : (good ? 0 : 2));
    if (valid) begin
      if (good) exp_ok++;
      else      exp_bad++;
    end
    clear_mon();
    send(pre, body, er_pos, valid && len > MAX, start);
    chk({name, " fwd_count"}, cap.size(), exp_fwd);
    mism = 0;
    n = (cap.size() < exp_fwd) ? cap.size() : exp_fwd;
    for (int i = 0; i < n; i++) if (cap[i] != body[i]) mism++;
    chk({name, " fwd_bytes_bad"}, mism, 0);
    if (exp_fwd > 0) begin
      chk({name, " latency"}, first_dv - start, 1);
      chk({name, " dv_span"}, last_dv - first_dv + 1, exp_fwd);
    end
    chk({name, " err_cycles"}, err_cnt, exp_err);
    if (exp_err > 0 && err_cyc.size() == exp_err) begin
      chk({name, " err_first_pos"}, err_cyc[0] - last_dv, 1);
      if (exp_err == 2) chk({name, " err_second_pos"}, err_cyc[1] - last_dv, 2);
    end
    chk({name, " frames_ok"}, int'(o_frames_ok), exp_ok);
    chk({name, " frames_bad"}, int'(o_frames_bad), exp_bad);
    chk({name, " end_state"}, int'(o_FSM_state), 0);
  endtask

  task automatic do_frame(input string name, input int pre_len, input bq_t body, input int er_pos);
    bq_t pre;
    for (int i = 0; i < pre_len; i++) pre.push_back(8'h55);
    pre.push_back(8'hD5);
    run(name, pre, body, er_pos);
  endtask

  // Reset lands on body byte 30 and releases on byte 35 of a frame in flight.
  task automatic reset_mid_frame();
    bq_t body;
    body = make_body(60);
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      @(posedge iclk); #1;
      i_rx_dv = 1'b1; i_rxd = (i == 7) ? 8'hD5 : 8'h55;
    end
    foreach (body[i]) begin
      @(posedge iclk); #1;
      if (i == 30) begin
        chk("rst pre_fwd", cap.size(), 29);
        i_rst_n = 1'b0;
        #1;
        chk("rst dv", int'(o_dv), 0);
        chk("rst error", int'(o_error), 0);
        chk("rst state", int'(o_FSM_state), 0);
        chk("rst rx_d", int'(o_rx_d), 0);
        chk("rst ok", int'(o_frames_ok), 0);
        chk("rst bad", int'(o_frames_bad), 0);
        clear_mon();
      end
      if (i == 35) i_rst_n = 1'b1;
      i_rx_dv = 1'b1; i_rxd = body[i];
    end
    @(posedge iclk); #1;
    i_rx_dv = 1'b0; i_rxd = 8'h00;
    repeat (8) @(posedge iclk);
    @(negedge iclk);
    exp_ok  = 0;
    exp_bad = 0;
    chk("rst after_fwd", cap.size(), 0);
    chk("rst after_err", err_cnt, 0);
    chk("rst after_ok", int'(o_frames_ok), 0);
    chk("rst after_bad", int'(o_frames_bad), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bq_t   b, pre;
    byte_t t;
    int    k, er, mode;
    clear_mon();
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("reset dv", int'(o_dv), 0);
    chk("reset error", int'(o_error), 0);
    chk("reset state", int'(o_FSM_state), 0);
    chk("reset rx_d", int'(o_rx_d), 0);
    chk("reset ok", int'(o_frames_ok), 0);
    chk("reset bad", int'(o_frames_bad), 0);
    @(posedge iclk); #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge iclk);

    do_frame("good64", 7, make_body(60), -1);
    b = make_body(60);
    t = b[17]; t[3] = ~t[3]; b[17] = t;
    do_frame("bitflip", 7, b, -1);
    do_frame("runt40", 7, make_body(36), -1);
    do_frame("runt63", 7, make_body(59), -1);
    do_frame("er20", 7, make_body(60), 20);
    do_frame("after_er", 7, make_body(60), -1);
    do_frame("max1536", 7, make_body(MAX - 4), -1);
    do_frame("over1600", 7, make_body(1596), -1);
    do_frame("short_pre", 1, make_body(70), -1);

    pre.delete(); pre.push_back(8'h12);
    run("garbage", pre, make_body(60), -1);
    pre.delete(); pre.push_back(8'h55); pre.push_back(8'h55); pre.push_back(8'h55);
    b.delete();
    run("pre_only", pre, b, -1);
    pre.delete(); pre.push_back(8'h55); pre.push_back(8'h55); pre.push_back(8'h3C);
    run("bad_pre", pre, make_body(60), -1);

    for (int n = 0; n < 12; n++) begin
      b    = make_body($urandom_range(36, 100));
      mode = $urandom_range(0, 2);
      er   = -1;
      if (mode == 1) begin
        k = $urandom_range(0, b.size() - 5);
        t = b[k];
        t[$urandom_range(0, 7)] ^= 1'b1;
        b[k] = t;
      end
      if (mode == 2) er = $urandom_range(0, b.size() - 1);
      do_frame($sformatf("rnd%0d", n), $urandom_range(1, 7), b, er);
    end

    reset_mid_frame();
    do_frame("post_rst", 7, make_body(60), -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
